rv_dbus_xbar: RTL and testbench

//  Data-bus router downstream of the core's data-bus master: takes one Wishbone-classic master request and

---
 rtl/rv_dbus_pkg.sv | 26 ++
 rtl/rv_dbus_timeout.sv | 35 +++
 rtl/rv_dbus_xbar.sv | 207 ++++++++++++++++++++
 tb/tb_rv_dbus_xbar.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_dbus_pkg.sv
// rv_dbus_pkg -- shared types and constants for the data-bus crossbar.
//  Widths are shared with the core's data-bus master; the state enum is
//  used by rv_dbus_xbar.
package rv_dbus_pkg;

   localparam int SEL_W    = 4;
   localparam int ADR_W    = 30;
   localparam int DAT_W    = 32;
   localparam int PREFIX_W = 16;

   localparam logic [DAT_W-1:0] ERR_RDATA_DEF = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ_LCL = 2'd1,
      REQ_EXT = 2'd2,
      RESP    = 2'd3
   } dbus_state_e;

   // Word address [31:2] -> byte-address bits [31:16] sit at the top 16 bits.
   function automatic logic adr_is_local(input logic [ADR_W-1:0] adr,
                                         input logic [PREFIX_W-1:0] prefix);
      return adr[ADR_W-1 -: PREFIX_W] == prefix;
   endfunction

endpackage

// File: rtl/rv_dbus_timeout.sv
// rv_dbus_timeout -- slave-wait watchdog timer.
//  Down-counter loaded with LOAD_VAL, decrements while en is high and stops
//  at zero; tc flags the terminal count.
// Ports:
//  clk_i   in  clock
//  rst_ni  in  asynchronous reset, active low
//  load    in  reload counter with LOAD_VAL
//  en      in  count enable
//  tc      out terminal count reached (counter == 0)
module rv_dbus_timeout #(
   parameter int               CNT_W    = 16,
   parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= LOAD_VAL;
      end else if (en && !tc) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/rv_dbus_xbar.sv
// rv_dbus_xbar -- data-bus router for one Wishbone-classic master.
//  Steers each request to the local peripheral port (address prefix match)
//  or to the external port, and returns a registered single-cycle ack with
//  read data. One transfer outstanding at a time.
//  Optional feature macro: RV_DBUS_TIMEOUT_EN -- watchdog that completes a
//  hung transfer with m_err_o and ERR_RDATA after TIMEOUT_CYCLES wait cycles.
//  Without it m_err_o is constant 0 and transfers wait indefinitely.
// Ports:
//  clk_i, rst_ni                    clock, async active-low reset
//  m_cyc_i/m_stb_i/m_we_i/m_sel_i/m_adr_i/m_dat_i   master request
//  m_dat_o/m_ack_o/m_err_o          master response (data held until next completion)
//  lcl_*_o / lcl_ack_i / lcl_dat_i  local peripheral port
//  ext_*_o / ext_ack_i / ext_dat_i  external bus port
//
// state   | meaning
// IDLE    | waiting for master cyc & stb; latches request on accept
// REQ_LCL | local port cyc/stb high, waiting for lcl_ack_i (or expiry)
// REQ_EXT | external port cyc/stb high, waiting for ext_ack_i (or expiry)
// RESP    | ack cycle; swallows the master's held stb, returns to IDLE
module rv_dbus_xbar
   import rv_dbus_pkg::*;
#(
   parameter int                   ENABLE_LOCALMAP = 1,
   parameter logic [PREFIX_W-1:0]  LOCAL_PREFIX    = 16'hFFFF,
   parameter int                   TIMEOUT_CYCLES  = 255,
   parameter logic [DAT_W-1:0]     ERR_RDATA       = ERR_RDATA_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,

   input  logic             m_cyc_i,
   input  logic             m_stb_i,
   input  logic             m_we_i,
   input  logic [SEL_W-1:0] m_sel_i,
   input  logic [ADR_W-1:0] m_adr_i,
   input  logic [DAT_W-1:0] m_dat_i,
   output logic [DAT_W-1:0] m_dat_o,
   output logic             m_ack_o,
   output logic             m_err_o,

   output logic             lcl_cyc_o,
   output logic             lcl_stb_o,
   output logic             lcl_we_o,
   output logic [SEL_W-1:0] lcl_sel_o,
   output logic [ADR_W-1:0] lcl_adr_o,
   output logic [DAT_W-1:0] lcl_dat_o,
   input  logic             lcl_ack_i,
   input  logic [DAT_W-1:0] lcl_dat_i,

   output logic             ext_cyc_o,
   output logic             ext_stb_o,
   output logic             ext_we_o,
   output logic [SEL_W-1:0] ext_sel_o,
   output logic [ADR_W-1:0] ext_adr_o,
   output logic [DAT_W-1:0] ext_dat_o,
   input  logic             ext_ack_i,
   input  logic [DAT_W-1:0] ext_dat_i
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("rv_dbus_xbar: TIMEOUT_CYCLES must be in 1..65535");
   end

   dbus_state_e state_q, state_d;

   logic             we_q;
   logic [SEL_W-1:0] sel_q;
   logic [ADR_W-1:0] adr_q;
   logic [DAT_W-1:0] wdat_q;
   logic [DAT_W-1:0] rdat_q;
   logic             ack_q, err_q;

   logic             accept;
   logic             in_req;
   logic             slv_ack;
   logic [DAT_W-1:0] slv_dat;
   logic             expired;
   logic             ack_d, err_d;
   logic             rdat_ld;
   logic [DAT_W-1:0] rdat_d;

   assign in_req  = (state_q == REQ_LCL) || (state_q == REQ_EXT);
   // Only the port actually being driven may complete the transfer.
   assign slv_ack = ((state_q == REQ_LCL) && lcl_ack_i) ||
                    ((state_q == REQ_EXT) && ext_ack_i);
   assign slv_dat = (state_q == REQ_LCL) ? lcl_dat_i : ext_dat_i;

`ifdef RV_DBUS_TIMEOUT_EN
   localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES - 1);
   logic to_tc;

   // Loaded as the request is accepted, so the first REQ cycle sees
   // TIMEOUT_CYCLES-1 and expiry lands on the last permitted wait cycle.
   rv_dbus_timeout #(
      .CNT_W    (16),
      .LOAD_VAL (TO_LOAD)
   ) u_timeout (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load   (accept),
      .en     (in_req),
      .tc     (to_tc)
   );

   assign expired = to_tc;
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rdat_ld = 1'b0;
      rdat_d  = slv_dat;
      unique case (state_q)
         IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               accept = 1'b1;
               if ((ENABLE_LOCALMAP != 0) && adr_is_local(m_adr_i, LOCAL_PREFIX)) begin
                  state_d = REQ_LCL;
               end else begin
                  state_d = REQ_EXT;
               end
            end
         end
         REQ_LCL, REQ_EXT: begin
            // A real ack on the expiry cycle takes priority over the error.
            if (slv_ack) begin
               ack_d   = 1'b1;
               rdat_ld = !we_q;
               state_d = RESP;
            end else if (expired) begin
               ack_d   = 1'b1;
               err_d   = 1'b1;
               rdat_ld = 1'b1;
               rdat_d  = ERR_RDATA;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q   <= 1'b0;
         sel_q  <= '0;
         adr_q  <= '0;
         wdat_q <= '0;
      end else if (accept) begin
         we_q   <= m_we_i;
         sel_q  <= m_sel_i;
         adr_q  <= m_adr_i;
         wdat_q <= m_dat_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdat_q <= '0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
         if (rdat_ld) begin
            rdat_q <= rdat_d;
         end
      end
   end

   assign m_dat_o = rdat_q;
   assign m_ack_o = ack_q;
   assign m_err_o = err_q;

   // cyc/stb are decoded from the registered state, so they fall on the
   // same edge that completes the transfer.
   assign lcl_cyc_o = (state_q == REQ_LCL);
   assign lcl_stb_o = (state_q == REQ_LCL);
   assign lcl_we_o  = we_q;
   assign lcl_sel_o = sel_q;
   assign lcl_adr_o = adr_q;
   assign lcl_dat_o = wdat_q;

   assign ext_cyc_o = (state_q == REQ_EXT);
   assign ext_stb_o = (state_q == REQ_EXT);
   assign ext_we_o  = we_q;
   assign ext_sel_o = sel_q;
   assign ext_adr_o = adr_q;
   assign ext_dat_o = wdat_q;

endmodule

// File: tb/tb_rv_dbus_xbar.sv
// tb_rv_dbus_xbar -- randomized self-checking bench for rv_dbus_xbar.
//  u_map uses the prefix decode, u_nomap has ENABLE_LOCALMAP=0; act selects
//  which instance receives slave acks and is being checked.
module tb_rv_dbus_xbar;

   localparam int TO = 4;
`ifdef RV_DBUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        m_cyc, m_stb, m_we;
   logic [3:0]  m_sel;
   logic [29:0] m_adr;
   logic [31:0] m_dat;
   logic        lcl_ack, ext_ack;
   logic [31:0] lcl_dat, ext_dat;
   logic        act;

   logic [31:0] m_dat_o   [2];
   logic        m_ack_o   [2];
   logic        m_err_o   [2];
   logic        lcl_cyc_o [2];
   logic        lcl_stb_o [2];
   logic        lcl_we_o  [2];
   logic [3:0]  lcl_sel_o [2];
   logic [29:0] lcl_adr_o [2];
   logic [31:0] lcl_dat_o [2];
   logic        ext_cyc_o [2];
   logic        ext_stb_o [2];
   logic        ext_we_o  [2];
   logic [3:0]  ext_sel_o [2];
   logic [29:0] ext_adr_o [2];
   logic [31:0] ext_dat_o [2];
   logic        lcl_ack_i [2];
   logic        ext_ack_i [2];

   assign lcl_ack_i[0] = lcl_ack & ~act;
   assign ext_ack_i[0] = ext_ack & ~act;
   assign lcl_ack_i[1] = lcl_ack & act;
   assign ext_ack_i[1] = ext_ack & act;

   rv_dbus_xbar #(
      .ENABLE_LOCALMAP (1),
      .LOCAL_PREFIX    (16'hFFFF),
      .TIMEOUT_CYCLES  (TO),
      .ERR_RDATA       (ERR_DATA)
   ) u_map (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .m_cyc_i (m_cyc), .m_stb_i (m_stb), .m_we_i (m_we), .m_sel_i (m_sel),
      .m_adr_i (m_adr), .m_dat_i (m_dat),
      .m_dat_o (m_dat_o[0]), .m_ack_o (m_ack_o[0]), .m_err_o (m_err_o[0]),
      .lcl_cyc_o (lcl_cyc_o[0]), .lcl_stb_o (lcl_stb_o[0]), .lcl_we_o (lcl_we_o[0]),
      .lcl_sel_o (lcl_sel_o[0]), .lcl_adr_o (lcl_adr_o[0]), .lcl_dat_o (lcl_dat_o[0]),
      .lcl_ack_i (lcl_ack_i[0]), .lcl_dat_i (lcl_dat),
      .ext_cyc_o (ext_cyc_o[0]), .ext_stb_o (ext_stb_o[0]), .ext_we_o (ext_we_o[0]),
      .ext_sel_o (ext_sel_o[0]), .ext_adr_o (ext_adr_o[0]), .ext_dat_o (ext_dat_o[0]),
      .ext_ack_i (ext_ack_i[0]), .ext_dat_i (ext_dat)
   );

   rv_dbus_xbar #(
      .ENABLE_LOCALMAP (0),
      .LOCAL_PREFIX    (16'hFFFF),
      .TIMEOUT_CYCLES  (TO),
      .ERR_RDATA       (ERR_DATA)
   ) u_nomap (
      .clk_i (clk_i), .rst_ni (rst_ni),
      .m_cyc_i (m_cyc), .m_stb_i (m_stb), .m_we_i (m_we), .m_sel_i (m_sel),
      .m_adr_i (m_adr), .m_dat_i (m_dat),
      .m_dat_o (m_dat_o[1]), .m_ack_o (m_ack_o[1]), .m_err_o (m_err_o[1]),
      .lcl_cyc_o (lcl_cyc_o[1]), .lcl_stb_o (lcl_stb_o[1]), .lcl_we_o (lcl_we_o[1]),
      .lcl_sel_o (lcl_sel_o[1]), .lcl_adr_o (lcl_adr_o[1]), .lcl_dat_o (lcl_dat_o[1]),
      .lcl_ack_i (lcl_ack_i[1]), .lcl_dat_i (lcl_dat),
      .ext_cyc_o (ext_cyc_o[1]), .ext_stb_o (ext_stb_o[1]), .ext_we_o (ext_we_o[1]),
      .ext_sel_o (ext_sel_o[1]), .ext_adr_o (ext_adr_o[1]), .ext_dat_o (ext_dat_o[1]),
      .ext_ack_i (ext_ack_i[1]), .ext_dat_i (ext_dat)
   );

   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] exp_rdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] ctl_of(input bit lcl);
      if (lcl) return {lcl_cyc_o[act], lcl_stb_o[act], lcl_we_o[act]};
      return {ext_cyc_o[act], ext_stb_o[act], ext_we_o[act]};
   endfunction

   function automatic logic [33:0] sel_adr_of(input bit lcl);
      if (lcl) return {lcl_sel_o[act], lcl_adr_o[act]};
      return {ext_sel_o[act], ext_adr_o[act]};
   endfunction

   function automatic logic [31:0] dat_of(input bit lcl);
      if (lcl) return lcl_dat_o[act];
      return ext_dat_o[act];
   endfunction

   function automatic logic [3:0] cycstb_all();
      return {lcl_cyc_o[act], lcl_stb_o[act], ext_cyc_o[act], ext_stb_o[act]};
   endfunction

   // One master transfer; the slave acks in wait cycle k_ack (1 = first
   // cycle its stb is high). With the watchdog, no ack by cycle TO means an
   // error completion at the end of cycle TO.
   task automatic do_xfer(input logic we, input logic [3:0] sel, input logic [29:0] adr,
                          input logic [31:0] wdat, input int k_ack, input logic [31:0] rdat,
                          input bit drop_stb);
      bit to_lcl;
      bit exp_err;
      bit done;
      int k;
      to_lcl  = (act == 1'b0) && (adr[29:14] == 16'hFFFF);
      exp_err = TO_EN && (k_ack > TO);

      // acks while idle must be ignored
      lcl_ack = 1'b1; ext_ack = 1'b1;
      lcl_dat = $urandom; ext_dat = $urandom;
      @(posedge clk_i); #1;
      chk("idle_ack_ignored", {m_ack_o[act], m_err_o[act], cycstb_all()}, 64'd0);
      lcl_ack = 1'b0; ext_ack = 1'b0;

      m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_dat = wdat;
      @(posedge clk_i); #1;
      k = 1;
      done = 1'b0;
      while (!done && k <= 16) begin
         chk("req_ctl", ctl_of(to_lcl), {2'b11, we});
         chk("req_sel_adr", sel_adr_of(to_lcl), {sel, adr});
         chk("req_wdat", dat_of(to_lcl), wdat);
         chk("other_port_idle", ctl_of(!to_lcl) >> 1, 64'd0);
         chk("no_early_ack", m_ack_o[act], 1'b0);
         if (drop_stb && k == 1) m_stb = 1'b0;
         m_dat = $urandom;
         if (to_lcl) begin
            lcl_ack = (k == k_ack); lcl_dat = (k == k_ack) ? rdat : $urandom;
            ext_ack = 1'($urandom_range(0, 1)); ext_dat = $urandom;
         end else begin
            ext_ack = (k == k_ack); ext_dat = (k == k_ack) ? rdat : $urandom;
            lcl_ack = 1'($urandom_range(0, 1)); lcl_dat = $urandom;
         end
         @(posedge clk_i); #1;
         lcl_ack = 1'b0; ext_ack = 1'b0;
         if (k == k_ack || (TO_EN && k == TO)) done = 1'b1;
         else k++;
      end
      if (!done) chk("xfer_cycle_bound", 64'd0, 64'd1);

      if (exp_err) exp_rdata = ERR_DATA;
      else if (!we) exp_rdata = rdat;
      chk("ack_err", {m_ack_o[act], m_err_o[act]}, {1'b1, exp_err});
      chk("rdata", m_dat_o[act], exp_rdata);
      chk("port_dropped", cycstb_all(), 64'd0);

      // master still holds stb during the response cycle
      @(posedge clk_i); #1;
      chk("ack_single", {m_ack_o[act], m_err_o[act]}, 64'd0);
      chk("rdata_hold", m_dat_o[act], exp_rdata);
      m_cyc = 1'b0; m_stb = 1'b0;
      @(posedge clk_i); #1;
      chk("no_reissue", {cycstb_all(), m_ack_o[act]}, 64'd0);
   endtask

   task automatic rand_xfer();
      logic [29:0] adr;
      adr = $urandom;
      if ($urandom_range(0, 1) == 1) adr[29:14] = 16'hFFFF;
      do_xfer(1'($urandom_range(0, 1)), 4'($urandom), adr, $urandom,
              int'($urandom_range(1, 7)), $urandom, ($urandom_range(0, 3) == 0));
   endtask

   initial begin
      m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = '0; m_adr = '0; m_dat = '0;
      lcl_ack = 1'b0; ext_ack = 1'b0; lcl_dat = '0; ext_dat = '0;
      act = 1'b0;
      exp_rdata = '0;

      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_ctl", {m_ack_o[0], m_err_o[0], lcl_cyc_o[0], lcl_stb_o[0], lcl_we_o[0],
                      ext_cyc_o[0], ext_stb_o[0], ext_we_o[0]}, 64'd0);
      chk("rst_mdat", m_dat_o[0], 64'd0);
      chk("rst_lcl_bus", {lcl_sel_o[0], lcl_adr_o[0], lcl_dat_o[0]}, 64'd0);
      chk("rst_ext_bus", {ext_sel_o[0], ext_adr_o[0], ext_dat_o[0]}, 64'd0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // read 0xFFFF0010 -> local, ack 3 cycles in
      do_xfer(1'b0, 4'hF, 30'h3FFFC004, 32'h0, 3, 32'h12345678, 1'b0);
      // write 0x00001000 -> external word 0x400, read data unchanged
      do_xfer(1'b1, 4'b0011, 30'h400, 32'h0000A5A5, 2, 32'h55AA55AA, 1'b0);
      // ack late (timeout if watchdog built in), then ack on the expiry cycle
      do_xfer(1'b0, 4'hF, 30'h0000123, 32'h0, TO + 3, 32'h0BADF00D, 1'b0);
      do_xfer(1'b0, 4'hF, 30'h0000124, 32'h0, TO, 32'hCAFEF00D, 1'b0);
      // minimum latency, stb dropped mid-transfer
      do_xfer(1'b0, 4'h1, 30'h3FFFC3FF, 32'h0, 1, 32'h13572468, 1'b1);

      // reset during REQ_EXT
      m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hC; m_adr = 30'h800; m_dat = 32'h77;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      chk("pre_rst_ext_busy", {ext_cyc_o[0], ext_stb_o[0]}, 64'd3);
      rst_ni = 1'b0;
      #1;
      exp_rdata = '0;
      chk("midrst_ctl", {m_ack_o[0], m_err_o[0], cycstb_all(), lcl_we_o[0], ext_we_o[0]}, 64'd0);
      chk("midrst_mdat", m_dat_o[0], 64'd0);
      chk("midrst_ext_bus", {ext_sel_o[0], ext_adr_o[0], ext_dat_o[0]}, 64'd0);
      m_cyc = 1'b0; m_stb = 1'b0;
      @(posedge clk_i); #3;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("postrst_no_ack", {m_ack_o[0], cycstb_all()}, 64'd0);
      do_xfer(1'b0, 4'hF, 30'h801, 32'h0, 2, 32'h24681357, 1'b0);

      for (int i = 0; i < 40; i++) rand_xfer();

      // no-localmap instance: prefix addresses go external
      rst_ni = 1'b0;
      act = 1'b1;
      exp_rdata = '0;
      @(posedge clk_i); #3;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      do_xfer(1'b0, 4'hF, 30'h3FFFC000, 32'h0, 1, 32'h89ABCDEF, 1'b0);
      for (int i = 0; i < 12; i++) rand_xfer();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
